sobel_gradient_gen: RTL and testbench
=====================================

Name: sobel_gradient_gen

Overview:
Streaming 3x3 Sobel convolution front end for the edge-detection path. Accepts a raster-order 8-bit grayscale pixel stream, buffers two previous lines, and emits signed vertical and horizontal gradients for every interior pixel. Outputs connect directly to the vert_in/horz_in inputs of the downstream gradient-magnitude (Newton square-root) stage.

Parameters:
WIDTH, 640, pixels per line (>=3)
HEIGHT, 480, lines per frame (>=3)
PIX_W, 8, input pixel width (unsigned)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
pixel_in  input  PIX_W  unsigned grayscale pixel
pixel_valid  input  1  pixel_in accepted this cycle when high
sof  input  1  start of frame; qualified by pixel_valid, marks pixel (0,0)
vert_out  output  16  signed vertical gradient Gy
horz_out  output  16  signed horizontal gradient Gx
out_valid  output  1  one-cycle pulse per emitted gradient pair

Behaviour:
- Reset (asynchronous, reset_n low): col/row counters = 0, 3x3 window regs = 0, vert_out = 0, horz_out = 0, out_valid = 0. Line-buffer RAM contents are not reset; outputs are gated until valid data exists.
- Accepted pixel = pixel_valid high at rising edge. pixel_valid low: counters, window, line buffers frozen; out_valid = 0.
- Counters: accepted pixel at (c,r) is written to the line buffer; col wraps WIDTH-1 -> 0 with row+1; at (WIDTH-1, HEIGHT-1) wraps to (0,0).
- sof with pixel_valid: that pixel is (0,0) regardless of counter state, including mid-frame. sof without pixel_valid is ignored.
- Window: rows p[0] (oldest, line r-2), p[1] (r-1), p[2] (current r); columns [0] oldest .. [2] newest. Each accepted pixel shifts the window left by one column, loading {linebuf2[c], linebuf1[c], pixel_in}.
- Gx = (p0[2] + 2*p1[2] + p2[2]) - (p0[0] + 2*p1[0] + p2[0]).
- Gy = (p2[0] + 2*p2[1] + p2[2]) - (p0[0] + 2*p0[1] + p0[2]).
- Range +/-1020 for PIX_W=8; computed at full precision, sign-extended to 16 bits, no saturation.
- Emission: pixel accepted at (c,r) with c>=2 and r>=2 -> next cycle out_valid = 1, gradients for the window centered at (c-1,r-1). Latency 1 cycle from the accepting edge. Border pixels (c<2 or r<2) are never emitted; windows spanning a line wrap are discarded.
- Exactly (WIDTH-2)*(HEIGHT-2) pulses per uninterrupted frame.
- vert_out/horz_out hold their last value when out_valid = 0.
- Reset mid-frame: outputs clear immediately; the next accepted pixel is (0,0).

Optional Feature:
SOBEL_GEN_COORD_EN: when defined, adds output ports out_x [15:0] and out_y [15:0] carrying the center coordinate (c-1, r-1), registered alongside out_valid and reset to 0. When undefined, these ports and their registers are absent; all other behaviour is identical.

Test Plan:
WIDTH=8, HEIGHT=6, continuous pixel_valid, sof on first pixel, constant pixel 100 -> 24 out_valid pulses, all vert_out = 0, horz_out = 0.
Horizontal ramp pixel = 10*x -> every pulse horz_out = 80, vert_out = 0; first pulse one cycle after the accept of pixel index 18 (row 2, col 2).
Vertical step, rows 0-2 = 0, rows 3-5 = 255 -> centers y=2 and y=3 give vert_out = 1020, y=1 and y=4 give 0; horz_out = 0 throughout.
Ramp as above with pixel_valid high every other cycle -> identical gradient sequence and count (24); out_valid never high in the cycle after a non-accept.
sof asserted mid-frame at counter (5,3) -> counters restart; the next pulse occurs after the 19th accepted pixel counted from the sof pixel.
reset_n pulsed low between edges mid-frame -> out_valid, vert_out, horz_out = 0 immediately; a full frame afterwards gives 24 correct pulses; with SOBEL_GEN_COORD_EN the first pulse carries out_x = 1, out_y = 1.

Source files
------------

// File: rtl/sobel_gradient_gen.sv
// Streaming 3x3 Sobel gradient generator.
// Takes a raster-order grayscale stream, keeps two line buffers and a 3x3 window,
// and emits signed Gy (vert_out) / Gx (horz_out) for every interior pixel, one
// cycle after the accepting edge.
// Optional feature macro: SOBEL_GEN_COORD_EN adds out_x/out_y center coordinates.
module sobel_gradient_gen #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned PIX_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PIX_W-1:0]        pixel_in,
  input  logic                    pixel_valid,
  input  logic                    sof,
  output logic signed [15:0]      vert_out,
  output logic signed [15:0]      horz_out,
  output logic                    out_valid
`ifdef SOBEL_GEN_COORD_EN
  ,
  output logic [15:0]             out_x,
  output logic [15:0]             out_y
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(HEIGHT);
  localparam int unsigned SW = PIX_W + 2;  // unsigned weighted-sum width
  localparam int unsigned GW = PIX_W + 3;  // signed gradient width

  logic [CW-1:0]    col_q, col_d, cur_col;
  logic [RW-1:0]    row_q, row_d, cur_row;
  logic [PIX_W-1:0] lb1_q [WIDTH];  // line r-1
  logic [PIX_W-1:0] lb2_q [WIDTH];  // line r-2
  logic [PIX_W-1:0] win_q [3][3];   // [row][col], row 0 oldest, col 2 newest
  logic [PIX_W-1:0] win_d [3][3];
  logic             emit;
  logic [SW-1:0]    gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [GW-1:0] gx, gy;
  logic signed [15:0]   vert_q, horz_q;
  logic                 valid_q;

  // sof forces the current pixel to (0,0); otherwise use the running counters.
  always_comb begin
    cur_col = sof ? '0 : col_q;
    cur_row = sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (pixel_valid) begin
      if (cur_col == CW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(HEIGHT - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  // Shifted window including the column being accepted this cycle.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb2_q[cur_col];
    win_d[1][2] = lb1_q[cur_col];
    win_d[2][2] = pixel_in;
  end

  // Gradients from the next window so the result lands one cycle after accept.
  always_comb begin
    gx_pos = SW'(win_d[0][2]) + (SW'(win_d[1][2]) << 1) + SW'(win_d[2][2]);
    gx_neg = SW'(win_d[0][0]) + (SW'(win_d[1][0]) << 1) + SW'(win_d[2][0]);
    gy_pos = SW'(win_d[2][0]) + (SW'(win_d[2][1]) << 1) + SW'(win_d[2][2]);
    gy_neg = SW'(win_d[0][0]) + (SW'(win_d[0][1]) << 1) + SW'(win_d[0][2]);
    gx     = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
    gy     = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    emit   = pixel_valid && (cur_col >= CW'(2)) && (cur_row >= RW'(2));
  end

  // Line buffers are plain RAM: no reset, written at the accepted column.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      lb2_q[cur_col] <= lb1_q[cur_col];
      lb1_q[cur_col] <= pixel_in;
    end
  end

  // Counters, window and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      vert_q  <= '0;
      horz_q  <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= emit;
      if (pixel_valid) begin
        win_q <= win_d;
      end
      if (emit) begin
        vert_q <= {{(16 - GW){gy[GW-1]}}, gy};
        horz_q <= {{(16 - GW){gx[GW-1]}}, gx};
      end
    end
  end

`ifdef SOBEL_GEN_COORD_EN
  logic [15:0] x_q, y_q;

  // Center coordinate of the emitted window, registered with out_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (emit) begin
      x_q <= 16'(cur_col) - 16'd1;
      y_q <= 16'(cur_row) - 16'd1;
    end
  end

  assign out_x = x_q;
  assign out_y = y_q;
`endif

  assign vert_out  = vert_q;
  assign horz_out  = horz_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_sobel_gradient_gen.sv
// Directed bench for sobel_gradient_gen (WIDTH=8, HEIGHT=6) with a scoreboard queue.
module tb_sobel_gradient_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [7:0]         pixel_in;
  logic               pixel_valid;
  logic               sof;
  logic signed [15:0] vert_out;
  logic signed [15:0] horz_out;
  logic               out_valid;
`ifdef SOBEL_GEN_COORD_EN
  logic [15:0]        out_x;
  logic [15:0]        out_y;
`endif

  sobel_gradient_gen #(
    .WIDTH (W),
    .HEIGHT(H),
    .PIX_W (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pixel_in   (pixel_in),
    .pixel_valid(pixel_valid),
    .sof        (sof),
    .vert_out   (vert_out),
    .horz_out   (horz_out),
    .out_valid  (out_valid)
`ifdef SOBEL_GEN_COORD_EN
    ,
    .out_x      (out_x),
    .out_y      (out_y)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entry: {gy, gx, x, y}.
  logic [63:0] sb_q[$];
  int          mc, mr;        // bench-side position of the next pixel
  logic [15:0] last_gy, last_gx;
  int          pulses;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int pat, input int x, input int y);
    case (pat)
      0:       return 100;
      1:       return 10 * x;
      2:       return (y >= 3) ? 255 : 0;
      default: return ((x * 37 + y * 91 + x * y * 13) ^ (x << 5)) & 255;
    endcase
  endfunction

  // Reference Sobel on the known image, centered at (cx, cy).
  function automatic logic [63:0] expect_at(input int pat, input int cx, input int cy);
    int gx, gy;
    gx = (pix(pat, cx + 1, cy - 1) + 2 * pix(pat, cx + 1, cy) + pix(pat, cx + 1, cy + 1))
       - (pix(pat, cx - 1, cy - 1) + 2 * pix(pat, cx - 1, cy) + pix(pat, cx - 1, cy + 1));
    gy = (pix(pat, cx - 1, cy + 1) + 2 * pix(pat, cx, cy + 1) + pix(pat, cx + 1, cy + 1))
       - (pix(pat, cx - 1, cy - 1) + 2 * pix(pat, cx, cy - 1) + pix(pat, cx + 1, cy - 1));
    return {16'(gy), 16'(gx), 16'(cx), 16'(cy)};
  endfunction

  // One clock: drive, push expectation, sample #1 after the edge, compare.
  task automatic step(input bit v, input bit s, input int pat);
    bit          emit;
    logic [63:0] e;
    if (v && s) begin
      mc = 0;
      mr = 0;
    end
    emit        = v && (mc >= 2) && (mr >= 2);
    pixel_valid = v;
    sof         = s;
    pixel_in    = v ? 8'(pix(pat, mc, mr)) : 8'($urandom_range(0, 255));
    if (emit) sb_q.push_back(expect_at(pat, mc - 1, mr - 1));
    @(posedge clk);
    #1;
    if (v) begin
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
    chk("out_valid", 16'(out_valid), 16'(emit));
    if (out_valid === 1'b1) begin
      chk("sb_nonempty", 16'(sb_q.size() > 0), 16'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("vert_out", vert_out, e[63:48]);
        chk("horz_out", horz_out, e[47:32]);
`ifdef SOBEL_GEN_COORD_EN
        chk("out_x", out_x, e[31:16]);
        chk("out_y", out_y, e[15:0]);
`endif
        last_gy = e[63:48];
        last_gx = e[47:32];
        pulses++;
      end
    end else begin
      chk("vert_hold", vert_out, last_gy);
      chk("horz_hold", horz_out, last_gx);
    end
  endtask

  task automatic run_frame(input int pat, input bit use_sof, input bit gaps);
    pulses = 0;
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, use_sof && (i == 0), pat);
      if (gaps) step(1'b0, 1'b1, pat);  // sof without pixel_valid must be ignored
    end
    chk("frame_pulses", 16'(pulses), 16'((W - 2) * (H - 2)));
  endtask

  initial begin
    reset_n     = 1'b0;
    pixel_valid = 1'b0;
    sof         = 1'b0;
    pixel_in    = '0;
    mc          = 0;
    mr          = 0;
    last_gy     = '0;
    last_gx     = '0;
    pulses      = 0;
    #12;
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_vert", vert_out, 16'd0);
    chk("rst_horz", horz_out, 16'd0);
    reset_n = 1'b1;

    run_frame(0, 1'b1, 1'b0);  // constant: all zero gradients
    run_frame(1, 1'b1, 1'b0);  // horizontal ramp: Gx = 80
    run_frame(2, 1'b1, 1'b0);  // vertical step: Gy = 1020 at y=2,3
    run_frame(1, 1'b1, 1'b1);  // ramp with every-other-cycle valid
    run_frame(3, 1'b1, 1'b0);  // irregular image, mixed signs

    // Abandon a frame at (5,3) and restart with sof.
    for (int i = 0; i < 3 * W + 5; i++) step(1'b1, i == 0, 1);
    run_frame(1, 1'b1, 1'b0);

    // Asynchronous reset between edges, mid-frame.
    for (int i = 0; i < 30; i++) step(1'b1, i == 0, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_valid", 16'(out_valid), 16'd0);
    chk("midrst_vert", vert_out, 16'd0);
    chk("midrst_horz", horz_out, 16'd0);
    #2 reset_n = 1'b1;
    sb_q.delete();
    mc      = 0;
    mr      = 0;
    last_gy = '0;
    last_gx = '0;
    run_frame(3, 1'b0, 1'b0);  // no sof: counters must already be at (0,0)

    chk("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
